// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional grant statistics counters enabled by ALU_SHARE_ARB_STATS_EN.
module alu_share_arb #(
    parameter int DW  = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_id,
`ifdef ALU_SHARE_ARB_STATS_EN
    output logic [7:0]     grant_cnt0,
    output logic [7:0]     grant_cnt1,
`endif
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic           prio;
    logic [OPW-1:0] op_r;
    logic [DW-1:0]  a_r, b_r;
    logic           id_r;
    logic           gnt0, gnt1, acc;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt0 = !prio;
                    gnt1 = prio;
                end else begin
                    gnt0 = req0_valid;
                    gnt1 = req1_valid;
                end
                if (req0_valid || req1_valid) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are suppressed during the reset cycle so no request is lost to a reset.
    assign req0_ready = gnt0 && !reset;
    assign req1_ready = gnt1 && !reset;
    assign acc        = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            id_r     <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                op_r <= req1_ready ? req1_op : req0_op;
                a_r  <= req1_ready ? req1_a  : req0_a;
                b_r  <= req1_ready ? req1_b  : req0_b;
                id_r <= req1_ready;
                prio <= !req1_ready;
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
                rsp_id   <= id_r;
            end
        end
    end

    // ALU inputs come only from the operand registers, forced to zero while in reset.
    assign alu_op    = reset ? '0 : op_r;
    assign alu_a     = reset ? '0 : a_r;
    assign alu_b     = reset ? '0 : b_r;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

`ifdef ALU_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
            if (req1_ready && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: randomized requesters, adder ALU model, negedge monitor.
module tb_alu_share_arb;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op, alu_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    logic       rv [2];
    logic [2:0] rop [2];
    logic [7:0] ra [2];
    logic [7:0] rb [2];
    int         rr_mode = 1;   // 0: stall, 1: always ready, 2: random

    assign req0_valid = rv[0]; assign req0_op = rop[0]; assign req0_a = ra[0]; assign req0_b = rb[0];
    assign req1_valid = rv[1]; assign req1_op = rop[1]; assign req1_a = ra[1]; assign req1_b = rb[1];
    assign alu_out = alu_a + alu_b;

    alu_share_arb dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef ALU_SHARE_ARB_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a, b, d;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t f;
    logic mprio = 1'b0, was_rst = 1'b0, first = 1'b1, chk_int = 1'b0, gexp;
    logic [7:0] hold_d;
    logic hold_id;
    int   last_acc = -1;
    int   mcnt [2];

    // Monitor: reference arbitration (round-robin pointer), expected results, latency and stability.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
            chk("rst_alu", {13'd0, alu_op, alu_a, alu_b}, 0);
            q.delete();
            mprio = 1'b0; was_rst = 1'b1; first = 1'b1;
            mcnt[0] = 0; mcnt[1] = 0;
        end else begin
            if (was_rst) begin
                chk("post_rst_state", {29'd0, rsp_valid, busy, rsp_id}, 0);
                chk("post_rst_data", rsp_data, 0);
                was_rst = 1'b0;
            end
            chk("ready_onehot", req0_ready & req1_ready, 0);
            if (busy) chk("busy_ready", req0_ready | req1_ready, 0);
            if (!busy && (req0_valid || req1_valid)) chk("idle_ready", req0_ready | req1_ready, 1);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                gexp = (req0_valid && req1_valid) ? mprio : req1_valid;
                chk("grant_port", req1_ready, gexp);
                f.id = req1_ready;
                f.op = rop[f.id]; f.a = ra[f.id]; f.b = rb[f.id];
                f.d = 8'((int'(f.a) + int'(f.b)) % 256);
                f.cyc = cyc;
                q.push_back(f);
                mprio = !f.id;
                if (mcnt[f.id] < 255) mcnt[f.id] = mcnt[f.id] + 1;
                if (chk_int && last_acc >= 0) chk("issue_interval", cyc - last_acc, 3);
                last_acc = cyc;
            end
            if (busy && !rsp_valid && q.size() > 0)
                chk("alu_passthru", {13'd0, alu_op, alu_a, alu_b}, {13'd0, q[0].op, q[0].a, q[0].b});
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    if (first) begin
                        chk("latency", cyc - q[0].cyc, 2);
                        chk("rsp_data", rsp_data, q[0].d);
                        chk("rsp_id", rsp_id, q[0].id);
                        hold_d = rsp_data; hold_id = rsp_id; first = 1'b0;
                    end else begin
                        chk("rsp_stable", {23'd0, rsp_id, rsp_data}, {23'd0, hold_id, hold_d});
                    end
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        first = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Requester model: holds valid and payload until its handshake, may drop valid when gapped.
    task automatic send(input int p, input int n, input bit gaps, input bit fix,
                        input logic [7:0] fa, input logic [7:0] fb);
        for (int k = 0; k < n; k++) begin
            int t;
            bit hs;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            rop[p] = 3'($urandom_range(0, 7));
            ra[p]  = fix ? fa : 8'($urandom_range(0, 255));
            rb[p]  = fix ? fb : 8'($urandom_range(0, 255));
            rv[p]  = 1'b1;
            t = 0; hs = 1'b0;
            while (!hs) begin
                @(negedge clk);
                hs = rv[p] && (p == 1 ? req1_ready : req0_ready);
                @(posedge clk); #1;
                if (!hs) begin
                    t++;
                    if (t > 200) begin chk("req_timeout", 1, 0); break; end
                    if (gaps && $urandom_range(0, 9) == 0) begin
                        rv[p] = 1'b0;
                        @(posedge clk); #1;
                        rv[p] = 1'b1;
                    end
                end
            end
            rv[p] = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("drain_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        int t;
        rv[0] = 0; rv[1] = 0;
        for (int i = 0; i < 2; i++) begin rop[i] = 0; ra[i] = 0; rb[i] = 0; end
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;

        // single request
        rv[0] = 1; rop[0] = 3'h2; ra[0] = 8'h10; rb[0] = 8'h22;
        @(negedge clk); chk("single_ready0", req0_ready, 1);
        @(posedge clk); #1; rv[0] = 0;
        @(negedge clk); chk("single_exec_busy", busy, 1);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_data", rsp_data, 8'h32);
        chk("single_rsp_id", rsp_id, 0);
        @(negedge clk); chk("single_busy_drop", busy, 0);
        @(posedge clk); #1;

        // contention: 4 ops per port, both continuously valid
        chk_int = 1; last_acc = -1;
        fork
            send(0, 4, 0, 0, 8'h0, 8'h0);
            send(1, 4, 0, 0, 8'h0, 8'h0);
        join
        drain();
        chk_int = 0;

        // response stall
        rr_mode = 0;
        send(1, 1, 0, 0, 8'h0, 8'h0);
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        chk("stall_rsp_seen", rsp_valid, 1);
        @(posedge clk); #1;
        rv[0] = 1; rop[0] = 3'h5; ra[0] = 8'h7F; rb[0] = 8'h81;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_readies", {30'd0, req1_ready, req0_ready}, 0);
            chk("stall_busy", busy, 1);
        end
        rr_mode = 1;
        @(negedge clk); chk("stall_release_hs", rsp_valid & rsp_ready, 1);
        @(negedge clk); chk("stall_next_grant", req0_ready, 1);
        @(posedge clk); #1; rv[0] = 0;
        drain();

        // reset during EXEC
        rv[0] = 1; rop[0] = 3'h1; ra[0] = 8'h55; rb[0] = 8'h11;
        @(negedge clk); chk("mid_accept", req0_ready, 1);
        @(posedge clk); #1;
        reset = 1;
        rop[1] = 3'h4; ra[1] = 8'h03; rb[1] = 8'h04; rv[1] = 1;
        @(negedge clk); chk("mid_exec_busy", busy, 1);
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        chk("mid_post_grant0", req0_ready, 1);
        chk("mid_post_grant1", req1_ready, 0);
        @(posedge clk); #1; rv[0] = 0;
        t = 0;
        while (!req1_ready && t < 20) begin @(negedge clk); t++; end
        chk("mid_port1_served", req1_ready, 1);
        @(posedge clk); #1; rv[1] = 0;
        drain();

        // wrap/carry, lone port 1 back-to-back
        chk_int = 1; last_acc = -1;
        send(1, 3, 0, 1, 8'hFF, 8'h01);
        drain();
        chk_int = 0;

        // randomized traffic with response backpressure
        rr_mode = 2;
        fork
            send(0, 100, 1, 0, 8'h0, 8'h0);
            send(1, 100, 1, 0, 8'h0, 8'h0);
        join
        rr_mode = 1;
        drain();

`ifdef ALU_SHARE_ARB_STATS_EN
        do_reset();
        send(0, 300, 0, 0, 8'h0, 8'h0);
        drain();
        chk("cnt0_sat", grant_cnt0, 255);
        chk("cnt0_model", grant_cnt0, mcnt[0]);
        chk("cnt1_zero", grant_cnt1, 0);
        do_reset();
        @(negedge clk);
        chk("cnt_rst", {grant_cnt1, grant_cnt0}, 0);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
